fxp8s_mm_sched: RTL
===================

// Module: fxp8s_mm_sched
// PURPOSE
//  Job scheduler/arbiter in front of the fxp8s 3x3 PE array. Shares the array between two requesters,
//  round-robin. For the granted requester it sequences one matrix-multiply job: stream A, stream B,
//  wait for the array result, drain NxN results. Drives the array's input-stream framing
//  (in_mat/in_new_row/in_mat_done) and output-stream handshake.
// PARAMETERS
//  N        3    matrix dimension (elements per row/col); counters are $clog2(N+1) bits
//  W        8    element width (fxp8s: sign bit [7], magnitude [6:0], LSB weight 2^-3)
//  TIMEOUT  255  max WAIT_OUT cycles before abort (used only with FXP8S_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1    clock, all logic on posedge
//  rst          in   1    synchronous reset, active-high
//  req          in   2    per-requester job request, level
//  gnt          out  2    one-hot grant, held for the whole job
//  req_valid    in   2    per-requester element valid
//  req_data     in   2*W  per-requester element; requester r on [r*W +: W]
//  req_ready    out  2    per-requester element accept; only granted bit can be 1
//  arr_en_in    out  1    element/frame valid to array
//  arr_rdy_in   in   1    array accepts element
//  arr_in_mat   out  1    1 = matrix A, 0 = matrix B
//  arr_new_row  out  1    first element of rows 1..N-1
//  arr_mat_done out  1    last element of current matrix
//  arr_in_data  out  W    element to array
//  arr_en_out   in   1    array has result available
//  arr_rdy_out  out  1    scheduler accepts result
//  arr_out_data in   W    result element
//  out_valid    out  1    result valid downstream
//  out_ready    in   1    downstream accept
//  out_data     out  W    result element (row-major)
//  out_id       out  1    requester index owning out_data
//  out_last     out  1    final (N*N-th) result of job
//  err          out  1    one-cycle abort pulse (0 when timeout feature compiled out)
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, rr pointer=0 (requester 0 has priority), row/col=0; every output 0.
//  - States: IDLE -> LOAD_A -> LOAD_B -> WAIT_OUT -> DRAIN -> IDLE.
//  - IDLE: req!=0 -> grant. Both set: grant rr side, then rr = ~granted. One set: grant it.
//    gnt registered: rises 1 cycle after req is sampled; LOAD_A entered the same cycle.
//  - LOAD_A/LOAD_B: arr_en_in = req_valid[g]; req_ready[g] = arr_rdy_in & arr_en_in;
//    arr_in_data = req_data[g]. Element transfers when req_valid[g] & arr_rdy_in. Combinational
//    path, zero latency. arr_in_mat = 1 in LOAD_A, 0 in LOAD_B.
//  - col/row counters advance per transfer; col wraps N-1 -> 0 and increments row.
//    arr_new_row = (col==0)&(row!=0); arr_mat_done = (row==N-1)&(col==N-1).
//    Transfer of the last element moves LOAD_A -> LOAD_B (or LOAD_B -> WAIT_OUT) and clears row/col.
//  - WAIT_OUT: array idle-waiting on compute; arr_en_in=0. arr_en_out=1 -> DRAIN next cycle.
//  - DRAIN: out_valid = arr_en_out; arr_rdy_out = out_ready & arr_en_out; out_data = arr_out_data;
//    out_id = g. Count transfers row-major; out_last = (row==N-1)&(col==N-1).
//    Last transfer -> IDLE, gnt=0 next cycle. Earliest next grant: the cycle after that.
//  - Backpressure: any stalled side holds state and counters; no element dropped or duplicated.
//  - req[g] falling mid-job is ignored; the job runs to completion. req_valid of the non-granted
//    side is ignored, and its req_ready stays 0.
//  - Outside LOAD_*: arr_en_in=0, req_ready=0. Outside DRAIN: out_valid=0, arr_rdy_out=0.
//  - Reset mid-job: immediate return to reset values, including rr pointer. The partially loaded
//    array must be reset alongside (shared rst).
// CONFIGURATION
//  FXP8S_SCHED_TIMEOUT_EN defined:
//  - Counter of $clog2(TIMEOUT+1) bits, cleared on entry to WAIT_OUT, increments while there.
//  - Count==TIMEOUT with arr_en_out=0: err=1 for 1 cycle, state -> IDLE, gnt=0, rr = ~g.
//  FXP8S_SCHED_TIMEOUT_EN undefined: no counter; WAIT_OUT waits indefinitely; err tied 0.
// TESTING
//  1 req=01, stream A=1..9, B=9..1, arr_en_out after 5 cyc, out_ready=1 -> gnt=01; arr_new_row on
//    elements 4,7 of each matrix; arr_mat_done on 9th; 9 outs, out_id=0, out_last on 9th; gnt=00.
//  2 req=11 held for 3 jobs -> grants in order 01,10,01; no cycle with both gnt bits set.
//  3 req_valid toggles 1/0 each cycle, arr_rdy_in low every 3rd cycle -> exactly 18 array
//    transfers, data order preserved.
//  4 DRAIN with out_ready=0 for 4 cycles at element 5 -> out_data stable, arr_rdy_out=0, resume at 5.
//  5 rst=1 at element 6 of LOAD_B, then req=10 -> all outputs 0 the cycle after rst; gnt=10 next
//    job, which starts at row/col 0.
//  6 [TIMEOUT_EN, TIMEOUT=8] arr_en_out never rises -> err pulse 8 cycles after WAIT_OUT entry,
//    gnt=00; job from other requester proceeds normally.

Source files
------------

// File: rtl/fxp8s_mm_sched.sv
// Round-robin job scheduler in front of the fxp8s NxN PE array: loads A then B, waits, drains NxN results.
// Optional WAIT_OUT watchdog: define FXP8S_SCHED_TIMEOUT_EN to abort a job whose result never appears.
`timescale 1ns/1ps
module fxp8s_mm_sched #(
    parameter int N       = 3,
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    output logic [1:0]     gnt,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_data,
    output logic [1:0]     req_ready,
    output logic           arr_en_in,
    input  logic           arr_rdy_in,
    output logic           arr_in_mat,
    output logic           arr_new_row,
    output logic           arr_mat_done,
    output logic [W-1:0]   arr_in_data,
    input  logic           arr_en_out,
    output logic           arr_rdy_out,
    input  logic [W-1:0]   arr_out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_id,
    output logic           out_last,
    output logic           err
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT_OUT, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;

    logic          g;
    logic          g_valid;
    logic [W-1:0]  g_data;
    logic          loading;
    logic          in_xfer, out_xfer, at_last, timeout_hit;

    assign g       = gnt_q[1];
    assign g_valid = g ? req_valid[1] : req_valid[0];
    assign g_data  = g ? req_data[2*W-1:W] : req_data[W-1:0];
    assign loading = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign in_xfer  = loading && g_valid && arr_rdy_in;
    assign out_xfer = (state_q == S_DRAIN) && arr_en_out && out_ready;
    assign at_last  = (row_q == CW'(N - 1)) && (col_q == CW'(N - 1));
    assign gnt      = gnt_q;

`ifdef FXP8S_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Zero on the first WAIT_OUT cycle, so the abort lands TIMEOUT cycles after entry.
    assign to_cnt_d    = (state_q == S_WAIT_OUT) ? to_cnt_q + 1'b1 : '0;
    assign timeout_hit = (state_q == S_WAIT_OUT) && (to_cnt_q == TW'(TIMEOUT)) && !arr_en_out;

    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    // Without the watchdog TIMEOUT has no effect; this comparison is constant-false.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            rr_q    <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        row_d   = row_q;
        col_d   = col_q;

        // One row-major position counter serves both the load and the drain phases.
        if (in_xfer || out_xfer) begin
            if (at_last) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == CW'(N - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (req == 2'b11) begin
                    gnt_d   = rr_q ? 2'b10 : 2'b01;
                    rr_d    = ~rr_q;
                    state_d = S_LOAD_A;
                end else if (req != 2'b00) begin
                    gnt_d   = req;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: if (in_xfer && at_last) state_d = S_LOAD_B;
            S_LOAD_B: if (in_xfer && at_last) state_d = S_WAIT_OUT;
            S_WAIT_OUT: begin
                if (arr_en_out) begin
                    state_d = S_DRAIN;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                    rr_d    = ~g;
                end
            end
            S_DRAIN: begin
                if (out_xfer && at_last) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 2'b00;
        arr_en_in    = 1'b0;
        arr_in_mat   = 1'b0;
        arr_new_row  = 1'b0;
        arr_mat_done = 1'b0;
        arr_in_data  = '0;
        arr_rdy_out  = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_id       = 1'b0;
        out_last     = 1'b0;
        err          = 1'b0;

        if (loading) begin
            arr_en_in    = g_valid;
            req_ready    = in_xfer ? gnt_q : 2'b00;
            arr_in_mat   = (state_q == S_LOAD_A);
            arr_new_row  = (col_q == '0) && (row_q != '0);
            arr_mat_done = at_last;
            arr_in_data  = g_data;
        end
        if (state_q == S_DRAIN) begin
            out_valid   = arr_en_out;
            arr_rdy_out = out_xfer;
            out_data    = arr_out_data;
            out_id      = g;
            out_last    = at_last;
        end
        if (state_q == S_WAIT_OUT) err = timeout_hit;
    end
endmodule
